// File: rtl/os_deskew_decoder.sv
// -----------------------------------------------------------------------------
// os_deskew_decoder
//
// Per-lane ordered-set framer and deskewer. Every active lane hunts for an OS
// start symbol on its own, collects a fixed number of symbols into a private
// buffer and then waits. When every active lane has a complete OS, all of them
// are released together as one lane-indexed word on outOs, and the lanes go
// back to hunting. A skew timer flushes all lanes when the slowest lane lags
// the first completed lane by too many cycles.
//
// Ports
//   clk                    single clock, all state on the rising edge
//   reset                  synchronous, active-low reset
//   gen                    1/2: start symbol 8'hBC; 3 and above: 8'h1E/8'h2D/8'hAA
//   numberOfDetectedLanes  active lane count (1/2/4/8/16, anything else -> 1)
//   short_os               0: 16-symbol OS, 1: 4-symbol OS (taken while all lanes hunt)
//   data                   lane L symbol k at [(L*SYMS+k)*8 +: 8], k=0 earliest
//   validFromLMC           beat qualifier; low beats freeze the lanes
//   valid                  one-cycle pulse, outOs carries one OS per active lane
//   outOs                  lane L OS at [L*128 +: 128], symbol n at [L*128+n*8 +: 8]
//   align_err              one-cycle pulse, a waiting lane saw a new start symbol
//   skew_err               one-cycle pulse, skew timeout flushed every lane
// -----------------------------------------------------------------------------
module os_deskew_decoder #(
    parameter int MAX_LANES = 16,
    parameter int SYMS      = 4,
    parameter int SKEW_MAX  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    gen,
    input  logic [4:0]                    numberOfDetectedLanes,
    input  logic                          short_os,
    input  logic [MAX_LANES*SYMS*8-1:0]   data,
    input  logic                          validFromLMC,
    output logic                          valid,
    output logic [MAX_LANES*128-1:0]      outOs,
    output logic                          align_err,
    output logic                          skew_err
);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } lane_state_e;

    // One OS buffer: 16 symbols, symbol n in slot n.
    typedef logic [15:0][7:0] os_buf_t;

    localparam int SKW = $clog2(SKEW_MAX + 1);

    // Lane state
    lane_state_e state_q [MAX_LANES];
    lane_state_e state_d [MAX_LANES];
    logic [4:0]  cnt_q   [MAX_LANES];
    logic [4:0]  cnt_d   [MAX_LANES];
    os_buf_t     os_q    [MAX_LANES];
    os_buf_t     os_d    [MAX_LANES];

    // Shared control
    logic                 short_q;
    logic                 short_eff;
    logic [4:0]           os_len;
    logic [4:0]           lane_num;
    logic [MAX_LANES-1:0] active;
    logic [MAX_LANES-1:0] align_hit;
    logic                 all_hunt;
    logic                 all_done;
    logic                 any_done;
    logic                 timeout;
    logic                 flush;
    logic                 skew_run_q;
    logic [SKW-1:0]       skew_cnt_q;
    logic [7:0]           sym;
    logic [MAX_LANES*128-1:0] os_word;

    // Start-symbol detection depends on the line encoding of the current rate.
    function automatic logic is_start(input logic [7:0] s, input logic [2:0] g);
        if (g >= 3'd3) begin
            return (s == 8'h1E) || (s == 8'h2D) || (s == 8'hAA);
        end
        return s == 8'hBC;
    endfunction

    // -------------------------------------------------------------------------
    // Lane count decode and OS length selection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in a combinational block gets a value on
        // every path first; a missing default silently becomes a latch.
        lane_num = 5'd1;
        case (numberOfDetectedLanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lane_num = numberOfDetectedLanes;
            default:                       lane_num = 5'd1;
        endcase
        for (int l = 0; l < MAX_LANES; l++) begin
            active[l] = (l < int'(lane_num));
        end

        // OS length may only change between OSs: take the live short_os while
        // every lane is hunting, otherwise keep the value latched at OS start.
        all_hunt = 1'b1;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (state_q[l] != S_HUNT) all_hunt = 1'b0;
        end
        short_eff = all_hunt ? short_os : short_q;
        os_len    = short_eff ? 5'd4 : 5'd16;
    end

    // -------------------------------------------------------------------------
    // Next-state: per-lane symbol scan
    // -------------------------------------------------------------------------
    // Symbols are consumed in order within a beat, so one lane may hunt, start
    // and collect within the same beat. Start symbols seen while collecting are
    // OS content. A lane that was already waiting flags any start symbol as an
    // overflow; a lane that completes mid-beat ignores the rest of that beat.
    always_comb begin
        sym = 8'h00;
        for (int l = 0; l < MAX_LANES; l++) begin
            state_d[l]   = state_q[l];
            cnt_d[l]     = cnt_q[l];
            os_d[l]      = os_q[l];
            align_hit[l] = 1'b0;

            if (!active[l]) begin
                state_d[l] = S_HUNT;
                cnt_d[l]   = 5'd0;
                os_d[l]    = '0;
            end else if (validFromLMC) begin
                for (int k = 0; k < SYMS; k++) begin
                    sym = data[(l*SYMS + k)*8 +: 8];
                    case (state_d[l])
                        S_HUNT: begin
                            if (is_start(sym, gen)) begin
                                os_d[l][0] = sym;
                                cnt_d[l]   = 5'd1;
                                state_d[l] = S_COLLECT;
                            end
                        end
                        S_COLLECT: begin
                            os_d[l][cnt_d[l][3:0]] = sym;
                            cnt_d[l] = cnt_d[l] + 5'd1;
                            if (cnt_d[l] == os_len) state_d[l] = S_DONE;
                        end
                        default: begin
                            if (state_q[l] == S_DONE && is_start(sym, gen)) begin
                                align_hit[l] = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: deskew and skew supervision
    // -------------------------------------------------------------------------
    // Completion is judged on the post-beat lane states so that valid follows
    // the completing beat by one cycle. A completion in the same cycle as the
    // timeout takes priority over the flush.
    always_comb begin
        all_done = 1'b1;
        any_done = 1'b0;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (active[l]) begin
                if (state_d[l] == S_DONE) any_done = 1'b1;
                else                      all_done = 1'b0;
            end
        end
        timeout = skew_run_q && !all_done && (skew_cnt_q == SKW'(SKEW_MAX - 1));
        flush   = all_done || timeout;
    end

    // -------------------------------------------------------------------------
    // Output: assemble the lane-indexed OS word
    // -------------------------------------------------------------------------
    // Buffers are cleared on every return to HUNT, so unused symbol slots of a
    // short OS and slots of inactive lanes are already zero.
    always_comb begin
        os_word = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            os_word[l*128 +: 128] = os_d[l];
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the OS buffers are reset as well as the FSMs; a lane
            // re-entering HUNT must start from an all-zero buffer because
            // short OSs publish the untouched slots as zero.
            for (int l = 0; l < MAX_LANES; l++) begin
                state_q[l] <= S_HUNT;
                cnt_q[l]   <= 5'd0;
                os_q[l]    <= '0;
            end
            short_q    <= 1'b0;
            skew_run_q <= 1'b0;
            skew_cnt_q <= '0;
            valid      <= 1'b0;
            align_err  <= 1'b0;
            skew_err   <= 1'b0;
            outOs      <= '0;
        end else begin
            for (int l = 0; l < MAX_LANES; l++) begin
                if (flush) begin
                    state_q[l] <= S_HUNT;
                    cnt_q[l]   <= 5'd0;
                    os_q[l]    <= '0;
                end else begin
                    state_q[l] <= state_d[l];
                    cnt_q[l]   <= cnt_d[l];
                    os_q[l]    <= os_d[l];
                end
            end

            short_q   <= short_eff;
            valid     <= all_done;
            skew_err  <= timeout;
            align_err <= |align_hit;

            // outOs is held between deliveries, including across skew flushes.
            if (all_done) outOs <= os_word;

            // The timer runs from the first lane completion until delivery or
            // flush, and keeps counting through unqualified beats.
            if (flush) begin
                skew_run_q <= 1'b0;
                skew_cnt_q <= '0;
            end else if (skew_run_q) begin
                skew_cnt_q <= skew_cnt_q + SKW'(1);
            end else if (any_done) begin
                skew_run_q <= 1'b1;
                skew_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_os_deskew_decoder.sv
// -----------------------------------------------------------------------------
// tb_os_deskew_decoder
//
// Self-checking bench for os_deskew_decoder. A queue-based model of the OS
// framing rules predicts the registered outputs every cycle; a compare process
// checks them on the falling edge. Directed scenarios add literal expectations,
// then randomized phases exercise lane counts, rates, short OSs, gaps in the
// beat qualifier, overflows and skew timeouts.
// -----------------------------------------------------------------------------
module tb_os_deskew_decoder;

    localparam int MAX_LANES = 16;
    localparam int SYMS      = 4;
    localparam int SKEW_MAX  = 8;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [2:0]                  gen;
    logic [4:0]                  numberOfDetectedLanes;
    logic                        short_os;
    logic [MAX_LANES*SYMS*8-1:0] data;
    logic                        validFromLMC;
    logic                        valid;
    logic [MAX_LANES*128-1:0]    outOs;
    logic                        align_err;
    logic                        skew_err;

    int n_checks = 0;
    int n_fail   = 0;

    os_deskew_decoder #(
        .MAX_LANES(MAX_LANES),
        .SYMS     (SYMS),
        .SKEW_MAX (SKEW_MAX)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .gen                  (gen),
        .numberOfDetectedLanes(numberOfDetectedLanes),
        .short_os             (short_os),
        .data                 (data),
        .validFromLMC         (validFromLMC),
        .valid                (valid),
        .outOs                (outOs),
        .align_err            (align_err),
        .skew_err             (skew_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: each lane is just a queue of collected symbols.
    // Empty = hunting, full (== OS length) = waiting for the other lanes.
    // ---------------------------------------------------------------------
    logic [7:0]               mq [MAX_LANES][$];
    logic [MAX_LANES*128-1:0] exp_os;
    logic                     exp_valid, exp_align, exp_skew;
    bit                       m_short;
    bit                       model_live = 0;
    bit                       t0_valid;
    int                       t0;
    int                       cyc = 0;

    function automatic bit m_is_start(input logic [7:0] s, input logic [2:0] g);
        if (g >= 3) return s inside {8'h1E, 8'h2D, 8'hAA};
        return s == 8'hBC;
    endfunction

    function automatic int lanes_of(input logic [4:0] v);
        if (v inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) return int'(v);
        return 1;
    endfunction

    always @(posedge clk) begin : model
        int         n, len;
        bit         all_empty, was_full, all_full, any_full;
        logic [7:0] s;
        model_live = 1;
        if (!reset) begin
            for (int l = 0; l < MAX_LANES; l++) mq[l].delete();
            m_short   = 0;
            t0_valid  = 0;
            exp_valid = 0;
            exp_align = 0;
            exp_skew  = 0;
            exp_os    = '0;
        end else begin
            exp_valid = 0;
            exp_align = 0;
            exp_skew  = 0;
            n = lanes_of(numberOfDetectedLanes);
            all_empty = 1;
            for (int l = 0; l < MAX_LANES; l++) if (mq[l].size() != 0) all_empty = 0;
            if (all_empty) m_short = short_os;
            len = m_short ? 4 : 16;
            for (int l = n; l < MAX_LANES; l++) mq[l].delete();
            if (validFromLMC) begin
                for (int l = 0; l < n; l++) begin
                    was_full = (mq[l].size() == len);
                    for (int k = 0; k < SYMS; k++) begin
                        s = data[(l*SYMS + k)*8 +: 8];
                        if (mq[l].size() == len) begin
                            if (was_full && m_is_start(s, gen)) exp_align = 1;
                        end else if (mq[l].size() != 0 || m_is_start(s, gen)) begin
                            mq[l].push_back(s);
                        end
                    end
                end
            end
            all_full = 1;
            any_full = 0;
            for (int l = 0; l < n; l++) begin
                if (mq[l].size() == len) any_full = 1;
                else                     all_full = 0;
            end
            if (all_full) begin
                exp_valid = 1;
                exp_os    = '0;
                for (int l = 0; l < n; l++)
                    for (int j = 0; j < mq[l].size(); j++)
                        exp_os[l*128 + j*8 +: 8] = mq[l][j];
                for (int l = 0; l < MAX_LANES; l++) mq[l].delete();
                t0_valid = 0;
            end else if (t0_valid && (cyc - t0 == SKEW_MAX)) begin
                exp_skew = 1;
                for (int l = 0; l < MAX_LANES; l++) mq[l].delete();
                t0_valid = 0;
            end else if (!t0_valid && any_full) begin
                t0       = cyc;
                t0_valid = 1;
            end
        end
        cyc++;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("valid", {127'd0, valid}, {127'd0, exp_valid});
            check("align_err", {127'd0, align_err}, {127'd0, exp_align});
            check("skew_err", {127'd0, skew_err}, {127'd0, exp_skew});
            for (int l = 0; l < MAX_LANES; l++)
                check($sformatf("outOs_lane%0d", l), outOs[l*128 +: 128], exp_os[l*128 +: 128]);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int lane, input int k, input logic [7:0] v);
        data[(lane*SYMS + k)*8 +: 8] = v;
    endtask

    // Places OS symbol idx = stream position - off on each symbol of a beat;
    // symbol 0 is the start symbol, symbol j>0 is {hi, j}, outside the OS 00.
    task automatic load_stream(input int lane, input int beat, input int off,
                               input logic [7:0] first, input logic [3:0] hi);
        for (int k = 0; k < SYMS; k++) begin
            int idx;
            idx = beat*SYMS + k - off;
            if (idx == 0)                 put(lane, k, first);
            else if (idx > 0 && idx < 16) put(lane, k, {hi, 4'(idx)});
            else                          put(lane, k, 8'h00);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    localparam logic [127:0] OS_BC0 = 128'h0F0E0D0C0B0A090807060504030201BC;
    localparam logic [127:0] OS_BC1 = 128'h1F1E1D1C1B1A191817161514131211BC;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0]           b;
        logic [MAX_LANES-1:0] quiet;
        logic [4:0]           lane_tab [8];
        lane_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd0, 5'd5};

        reset                 = 1'b0;
        gen                   = 3'd1;
        numberOfDetectedLanes = 5'd1;
        short_os              = 1'b0;
        data                  = '0;
        validFromLMC          = 1'b0;
        do_reset();
        check("reset_valid", {127'd0, valid}, 128'd0);
        check("reset_outOs", outOs[127:0], 128'd0);

        // x1, gen 1: BC at k=0 then 01..0F over four beats
        validFromLMC = 1'b1;
        for (int bt = 0; bt < 4; bt++) begin
            data = {16{$urandom()}};
            load_stream(0, bt, 0, 8'hBC, 4'h0);
            tick();
            if (bt < 3) check("x1_early_valid", {127'd0, valid}, 128'd0);
        end
        check("x1_valid", {127'd0, valid}, 128'd1);
        check("x1_lane0", outOs[127:0], OS_BC0);
        check("x1_lane1_zero", outOs[255:128], 128'd0);
        data = '0;
        tick();
        check("x1_valid_pulse", {127'd0, valid}, 128'd0);

        // x4, gen 3: lane L starts at k=L, completions spread over two beats
        do_reset();
        gen                   = 3'd3;
        numberOfDetectedLanes = 5'd4;
        for (int bt = 0; bt < 5; bt++) begin
            data = '0;
            for (int l = 0; l < 4; l++) load_stream(l, bt, l, 8'h1E, 4'(l));
            tick();
            if (bt < 4) check("x4_early_valid", {127'd0, valid}, 128'd0);
        end
        check("x4_valid", {127'd0, valid}, 128'd1);
        check("x4_lane0", outOs[127:0], 128'h0F0E0D0C0B0A090807060504030201_1E);
        check("x4_lane3", outOs[511:384], 128'h3F3E3D3C3B3A393837363534333231_1E);

        // x2 short OS, gen 1: both lanes complete in one beat
        do_reset();
        gen                   = 3'd1;
        numberOfDetectedLanes = 5'd2;
        short_os              = 1'b1;
        data                  = '0;
        put(0, 0, 8'hBC); put(0, 1, 8'hA1); put(0, 2, 8'hB2); put(0, 3, 8'hC3);
        put(1, 0, 8'hBC); put(1, 1, 8'h11); put(1, 2, 8'h22); put(1, 3, 8'h33);
        tick();
        check("short_valid", {127'd0, valid}, 128'd1);
        check("short_lane0", outOs[127:0], 128'hC3B2A1BC);
        check("short_lane1", outOs[255:128], 128'h332211BC);
        check("short_lane2", outOs[383:256], 128'd0);

        // Skew timeout: lane 0 completes, lane 1 stays silent
        short_os = 1'b0;
        for (int bt = 0; bt < 4; bt++) begin
            data = '0;
            load_stream(0, bt, 0, 8'hBC, 4'h0);
            tick();
        end
        data = '0;
        for (int c = 0; c < 7; c++) begin
            tick();
            check("skew_early", {126'd0, skew_err, valid}, 128'd0);
        end
        tick();
        check("skew_err", {127'd0, skew_err}, 128'd1);
        check("skew_no_valid", {127'd0, valid}, 128'd0);
        check("skew_outOs_held", outOs[127:0], 128'hC3B2A1BC);
        for (int bt = 0; bt < 4; bt++) begin
            data = '0;
            load_stream(0, bt, 0, 8'hBC, 4'h0);
            load_stream(1, bt, 0, 8'hBC, 4'h1);
            tick();
        end
        check("post_skew_valid", {127'd0, valid}, 128'd1);
        check("post_skew_lane1", outOs[255:128], OS_BC1);

        // Overflow: lane 0 waits, sees a new BC before lane 1 completes
        for (int bt = 0; bt < 8; bt++) begin
            data = '0;
            if (bt < 4)  load_stream(0, bt, 0, 8'hBC, 4'h0);
            if (bt == 4) put(0, 0, 8'hBC);
            load_stream(1, bt, 16, 8'hBC, 4'h1);
            tick();
            if (bt == 4) check("ovf_align", {127'd0, align_err}, 128'd1);
            if (bt == 5) check("ovf_align_pulse", {127'd0, align_err}, 128'd0);
        end
        check("ovf_valid", {127'd0, valid}, 128'd1);
        check("ovf_lane0", outOs[127:0], OS_BC0);
        check("ovf_lane1", outOs[255:128], OS_BC1);

        // Reset during collection with the qualifier toggling
        numberOfDetectedLanes = 5'd1;
        data = '0;
        load_stream(0, 0, 0, 8'hBC, 4'h0);
        tick();
        validFromLMC = 1'b0;
        load_stream(0, 1, 0, 8'hBC, 4'h0);
        tick();
        validFromLMC = 1'b1;
        reset        = 1'b0;
        tick();
        check("rst_mid_outs", {125'd0, valid, align_err, skew_err}, 128'd0);
        check("rst_mid_lane0", outOs[127:0], 128'd0);
        check("rst_mid_lane1", outOs[255:128], 128'd0);
        reset = 1'b1;
        for (int bt = 0; bt < 4; bt++) begin
            data = '0;
            load_stream(0, bt, 0, 8'hBC, 4'h0);
            tick();
        end
        check("rst_after_valid", {127'd0, valid}, 128'd1);
        check("rst_after_lane0", outOs[127:0], OS_BC0);

        // Randomized phases
        for (int p = 0; p < 12; p++) begin
            reset = 1'b0;
            tick();
            numberOfDetectedLanes = lane_tab[$urandom_range(0, 7)];
            gen                   = 3'($urandom_range(1, 5));
            for (int l = 0; l < MAX_LANES; l++) quiet[l] = ($urandom_range(0, 7) == 0);
            reset = 1'b1;
            for (int c = 0; c < 150; c++) begin
                reset        = ($urandom_range(0, 299) != 0);
                validFromLMC = ($urandom_range(0, 4) != 0);
                short_os     = 1'($urandom_range(0, 1));
                for (int l = 0; l < MAX_LANES; l++) begin
                    for (int k = 0; k < SYMS; k++) begin
                        if (!quiet[l] && $urandom_range(0, 5) == 0) begin
                            if (gen < 3) b = 8'hBC;
                            else case ($urandom_range(0, 2))
                                0:       b = 8'h1E;
                                1:       b = 8'h2D;
                                default: b = 8'hAA;
                            endcase
                        end else begin
                            b = 8'($urandom_range(0, 255));
                            if (quiet[l] && m_is_start(b, gen)) b = 8'h00;
                        end
                        put(l, k, b);
                    end
                end
                tick();
            end
        end
        reset = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
